// File: rtl/wb_fetch_master.sv
// Pipelined Wishbone instruction-fetch master: prefetches 64-bit doublewords into a small FIFO
// and hands 32-bit instructions (low half first) to decode, with redirect flush.
module wb_fetch_master #(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  output logic [63:0] o_wb_adr,
  output logic [63:0] o_wb_dat,
  input  logic [63:0] i_wb_dat,
  output logic        o_wb_we,
  output logic [7:0]  o_wb_sel,
  output logic        o_wb_stb,
  input  logic        i_wb_ack,
  input  logic        i_wb_stall,
  output logic        o_wb_cyc,
  input  logic        i_redirect,
  input  logic [63:0] i_redirect_pc,
  output logic        o_insn_valid,
  output logic [31:0] o_insn,
  output logic [63:0] o_insn_pc,
  input  logic        i_insn_ready
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int DW = CW + 3;
  localparam logic [CW:0]   DEPTH_C    = (CW + 1)'(FIFO_DEPTH);
  localparam logic [DW-1:0] DISC_LIMIT = DW'((1 << DW) - 1 - FIFO_DEPTH);

  typedef enum logic {IDLE, BUS} state_e;

  state_e        state_q, state_d;
  logic          stb_q, stb_d;
  logic [63:3]   fetch_pc_q, fetch_pc_d;
  logic [63:3]   head_addr_q, head_addr_d;
  logic          head_half_q, head_half_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [DW-1:0] discard_q, discard_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [63:0]   mem_q [FIFO_DEPTH];

  logic        cyc, accept, ack, drop_ack, live_ack;
  logic        valid, consume, pop, push, credit_ok;
  logic [63:0] head_dw;
  logic        unused_pc_bits;

  assign cyc      = (state_q == BUS);
  assign accept   = stb_q & ~i_wb_stall;
  assign ack      = i_wb_ack & cyc;
  assign drop_ack = ack & (discard_q != '0);
  assign live_ack = ack & (discard_q == '0);
  assign valid    = (count_q != '0);
  assign consume  = valid & i_insn_ready & ~i_redirect;
  assign pop      = consume & head_half_q;
  assign push     = live_ack & ~i_redirect;
  assign unused_pc_bits = ^i_redirect_pc[1:0];

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    head_addr_d = head_addr_q;
    head_half_d = head_half_q;
    count_d     = count_q;
    outst_d     = outst_q;
    discard_d   = discard_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;

    if (i_redirect) begin
      // Every request the slave still owes us (including one accepted right now) becomes stale.
      fetch_pc_d  = i_redirect_pc[63:3];
      head_addr_d = i_redirect_pc[63:3];
      head_half_d = i_redirect_pc[2];
      count_d     = '0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      outst_d     = '0;
      discard_d   = discard_q + DW'(outst_q) + DW'(accept) - DW'(ack);
    end else begin
      if (accept) fetch_pc_d = fetch_pc_q + 61'd1;
      if (push)   wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop) begin
        rd_ptr_d    = rd_ptr_q + PW'(1);
        head_addr_d = head_addr_q + 61'd1;
      end
      if (consume) head_half_d = ~head_half_q;
      count_d   = count_q + CW'(push) - CW'(pop);
      outst_d   = outst_q + CW'(accept) - CW'(live_ack);
      discard_d = discard_q - DW'(drop_ack);
    end

    credit_ok = (({1'b0, count_d} + {1'b0, outst_d}) < DEPTH_C);
    // Cap on stale acks keeps the discard counter from wrapping under a redirect storm.
    stb_d     = credit_ok && (discard_d < DISC_LIMIT);
    state_d   = (stb_d || (outst_d != '0) || (discard_d != '0)) ? BUS : IDLE;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= IDLE;
      stb_q       <= 1'b0;
      fetch_pc_q  <= RESET_PC[63:3];
      head_addr_q <= RESET_PC[63:3];
      head_half_q <= RESET_PC[2];
      count_q     <= '0;
      outst_q     <= '0;
      discard_q   <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      stb_q       <= stb_d;
      fetch_pc_q  <= fetch_pc_d;
      head_addr_q <= head_addr_d;
      head_half_q <= head_half_d;
      count_q     <= count_d;
      outst_q     <= outst_d;
      discard_q   <= discard_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= i_wb_dat;
  end

  assign head_dw      = mem_q[rd_ptr_q];
  assign o_wb_adr     = {fetch_pc_q, 3'b000};
  assign o_wb_dat     = 64'h0;
  assign o_wb_we      = 1'b0;
  assign o_wb_sel     = stb_q ? 8'hFF : 8'h00;
  assign o_wb_stb     = stb_q;
  assign o_wb_cyc     = cyc;
  assign o_insn_valid = valid;
  assign o_insn       = valid ? (head_half_q ? head_dw[63:32] : head_dw[31:0]) : 32'h0;
  assign o_insn_pc    = valid ? {head_addr_q, head_half_q, 2'b00} : 64'h0;

endmodule
